// File: rtl/ps2_pkg.sv
// PS/2 scan decoder shared definitions: frame fields, Set 2 codes,
// decoder states and the 11-bit key event record.
package ps2_pkg;

  localparam int FR_W     = 11;
  localparam int FR_START = 0;
  localparam int FR_D_LSB = 1;
  localparam int FR_D_MSB = 8;
  localparam int FR_PAR   = 9;
  localparam int FR_STOP  = 10;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_PAUSE  = 8'h77;

  localparam logic [7:0] RSP_BAT  = 8'hAA;
  localparam logic [7:0] RSP_ACK  = 8'hFA;
  localparam logic [7:0] RSP_ECHO = 8'hEE;
  localparam logic [7:0] RSP_RSND = 8'hFE;
  localparam logic [7:0] RSP_ERR0 = 8'h00;
  localparam logic [7:0] RSP_ERR1 = 8'hFF;

  // bytes that follow E1 in the Pause sequence
  localparam logic [2:0] PAUSE_LEN = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    GOT_E0,
    GOT_F0,
    GOT_E0F0,
    PAUSE
  } state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       pause;
  } ps2_ev_t;

  localparam int EV_W = $bits(ps2_ev_t);

  function automatic logic frame_ok(
    input logic [FR_W-1:0] f
  );
    return !f[FR_START] && f[FR_STOP] &&
           (^f[FR_PAR:FR_D_LSB]);
  endfunction

  function automatic logic is_rsp(
    input logic [7:0] b
  );
    return b inside {RSP_BAT, RSP_ACK,
                     RSP_ECHO, RSP_RSND,
                     RSP_ERR0, RSP_ERR1};
  endfunction

  function automatic ps2_ev_t mk_ev(
    input logic [7:0] code,
    input logic       ext,
    input logic       brk,
    input logic       pause
  );
    ps2_ev_t e;
    e.code  = code;
    e.ext   = ext;
    e.brk   = brk;
    e.pause = pause;
    return e;
  endfunction

endpackage

// File: rtl/ps2_scan_decoder_if.sv
// Key event valid/ready bus: master = decoder, slave = consumer.
// ev_valid/ev_code/ev_ext/ev_break/ev_pause forward, ev_ready back.
interface ps2_scan_decoder_if;
  import ps2_pkg::*;

  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic       ev_pause;

  modport master (
    output ev_valid, ev_code, ev_ext,
    output ev_break, ev_pause,
    input  ev_ready
  );

  modport slave (
    input  ev_valid, ev_code, ev_ext,
    input  ev_break, ev_pause,
    output ev_ready
  );

endinterface

// File: rtl/ps2_event_fifo.sv
// Show-ahead synchronous FIFO. Ports: i_push/i_data write,
// i_pop read, o_data head (0 when empty), o_full, o_empty.
module ps2_event_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;

  logic w_pop;
  logic w_push;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  // a pop frees the slot this cycle, so full+pop still accepts
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_data  = o_empty ? '0 : r_mem[r_rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop)
        r_rp <= r_rp + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 Set 2 decoder: frame check, prefix FSM, timeout, event FIFO.
// In: frame_valid/frame. Out: ev bus, err_cnt, sticky overflow.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_valid,
  input  logic [FR_W-1:0]  frame,
  ps2_scan_decoder_if.master ev,
  output logic [7:0]       err_cnt,
  output logic             overflow
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ?
                      $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST =
    CW'(TIMEOUT_CYCLES - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_rem;
  logic [2:0]    w_rem_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [7:0]    r_err;
  logic          r_ovf;
  logic          r_push;
  ps2_ev_t       r_ev;

  logic          w_good;
  logic [7:0]    w_byte;
  logic          w_push;
  ps2_ev_t       w_ev;
  logic          w_err;
  logic          w_full;
  logic          w_empty;
  ps2_ev_t       w_head;

  assign w_good = frame_ok(frame);
  assign w_byte = frame[FR_D_MSB:FR_D_LSB];

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_cnt_nxt   = r_cnt;
    w_push      = 1'b0;
    w_ev        = '0;
    w_err       = 1'b0;
    if (frame_valid) begin
      w_cnt_nxt = '0;
      if (!w_good) begin
        w_err       = 1'b1;
        w_state_nxt = IDLE;
      end else begin
        unique case (r_state)
          IDLE: begin
            unique case (1'b1)
              (w_byte == SC_E0): w_state_nxt = GOT_E0;
              (w_byte == SC_F0): w_state_nxt = GOT_F0;
              (w_byte == SC_E1): begin
                w_state_nxt = PAUSE;
                w_rem_nxt   = PAUSE_LEN;
              end
              is_rsp(w_byte): ;
              default: begin
                w_push = 1'b1;
                w_ev   = mk_ev(w_byte, 1'b0, 1'b0, 1'b0);
              end
            endcase
          end
          GOT_E0: begin
            w_state_nxt = IDLE;
            unique case (1'b1)
              (w_byte == SC_F0): w_state_nxt = GOT_E0F0;
              (w_byte == SC_LSHIFT): ;
              (w_byte == SC_E0 || w_byte == SC_E1):
                w_err = 1'b1;
              default: begin
                w_push = 1'b1;
                w_ev   = mk_ev(w_byte, 1'b1, 1'b0, 1'b0);
              end
            endcase
          end
          GOT_F0: begin
            w_state_nxt = IDLE;
            unique case (1'b1)
              (w_byte inside {SC_E0, SC_F0, SC_E1}):
                w_err = 1'b1;
              default: begin
                w_push = 1'b1;
                w_ev   = mk_ev(w_byte, 1'b0, 1'b1, 1'b0);
              end
            endcase
          end
          GOT_E0F0: begin
            w_state_nxt = IDLE;
            unique case (1'b1)
              (w_byte == SC_LSHIFT): ;
              (w_byte inside {SC_E0, SC_F0, SC_E1}):
                w_err = 1'b1;
              default: begin
                w_push = 1'b1;
                w_ev   = mk_ev(w_byte, 1'b1, 1'b1, 1'b0);
              end
            endcase
          end
          PAUSE: begin
            if (r_rem == 3'd1) begin
              w_state_nxt = IDLE;
              w_rem_nxt   = '0;
              w_push      = 1'b1;
              w_ev        = mk_ev(SC_PAUSE, 1'b0, 1'b0, 1'b1);
            end else begin
              w_rem_nxt = r_rem - 3'd1;
            end
          end
          default: w_state_nxt = IDLE;
        endcase
      end
    end else if (r_state != IDLE) begin
      if (r_cnt == TO_LAST) begin
        w_err       = 1'b1;
        w_state_nxt = IDLE;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
    if (w_state_nxt == IDLE)
      w_cnt_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_err   <= '0;
      r_push  <= 1'b0;
      r_ev    <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_cnt   <= w_cnt_nxt;
      r_push  <= w_push;
      r_ev    <= w_ev;
      if (w_err && r_err != 8'hFF)
        r_err <= r_err + 8'd1;
      // full with no pop: the FIFO drops the staged event
      if (r_push && w_full && !ev.ev_ready)
        r_ovf <= 1'b1;
    end
  end

  ps2_event_fifo #(
    .W     (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_push),
    .i_data  (r_ev),
    .i_pop   (ev.ev_ready),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign ev.ev_valid = ~w_empty;
  assign ev.ev_code  = w_head.code;
  assign ev.ev_ext   = w_head.ext;
  assign ev.ev_break = w_head.brk;
  assign ev.ev_pause = w_head.pause;
  assign err_cnt     = r_err;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Bench for ps2_scan_decoder: directed plan steps plus a random
// byte stream checked against a sequence-level reference model.
module tb_ps2_scan_decoder;

  localparam int DEPTH = 4;
  localparam int TO    = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_valid = 1'b0;
  logic [10:0] frame = '0;
  logic [7:0]  err_cnt;
  logic        overflow;

  ps2_scan_decoder_if ev_if();

  ps2_scan_decoder #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_valid (frame_valid),
    .frame       (frame),
    .ev          (ev_if),
    .err_cnt     (err_cnt),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       pause;
  } xev_t;

  xev_t       exp_q[$];
  logic [7:0] seq[$];
  int         exp_err;
  bit         exp_ovf;
  int         vectors;
  int         miscompares;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // bad: 0 good, 1 parity flipped, 2 stop=0, 3 start=1
  function automatic logic [10:0] mk(input logic [7:0] b,
                                     input int bad);
    logic [10:0] f;
    f = {1'b1, ~^b, b, 1'b0};
    if (bad == 1) f[9]  = ~f[9];
    if (bad == 2) f[10] = 1'b0;
    if (bad == 3) f[0]  = 1'b1;
    return f;
  endfunction

  function automatic void m_push(input logic [7:0] c,
                                 input logic x,
                                 input logic b,
                                 input logic p);
    xev_t e;
    e = '{code: c, ext: x, brk: b, pause: p};
    if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
    else exp_q.push_back(e);
  endfunction

  function automatic void m_err();
    if (exp_err < 255) exp_err++;
  endfunction

  function automatic bit is_pfx(input logic [7:0] b);
    return b == 8'hE0 || b == 8'hF0 || b == 8'hE1;
  endfunction

  function automatic bit is_rsp(input logic [7:0] b);
    return b == 8'hAA || b == 8'hFA || b == 8'hEE ||
           b == 8'hFE || b == 8'h00 || b == 8'hFF;
  endfunction

  // Interprets the whole pending byte sequence at once.
  function automatic void m_byte(input logic [7:0] b);
    int n;
    logic x;
    logic k;
    seq.push_back(b);
    n = seq.size();
    if (seq[0] == 8'hE1) begin
      if (n == 8) begin
        m_push(8'h77, 1'b0, 1'b0, 1'b1);
        seq.delete();
      end
      return;
    end
    if (n == 1) begin
      if (b == 8'hE0 || b == 8'hF0) return;
      seq.delete();
      if (!is_rsp(b)) m_push(b, 1'b0, 1'b0, 1'b0);
      return;
    end
    if (n == 2 && seq[0] == 8'hE0 && b == 8'hF0) return;
    x = (seq[0] == 8'hE0);
    k = (seq[n-2] == 8'hF0);
    seq.delete();
    if (is_pfx(b)) m_err();
    else if (!(x && b == 8'h12)) m_push(b, x, k, 1'b0);
  endfunction

  task automatic send(input logic [7:0] b, input int bad);
    @(negedge clk);
    frame       = mk(b, bad);
    frame_valid = 1'b1;
    if (bad == 0) m_byte(b);
    else begin
      seq.delete();
      m_err();
    end
    @(negedge clk);
    frame_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int   g;
    xev_t e;
    g = 0;
    @(negedge clk);
    while (ev_if.ev_valid === 1'b1 && g < 16) begin
      g++;
      if (exp_q.size() == 0) begin
        chk({tag, "_valid"}, ev_if.ev_valid, 0);
      end else begin
        e = exp_q.pop_front();
        chk({tag, "_code"}, ev_if.ev_code, e.code);
        chk({tag, "_ext"}, ev_if.ev_ext, e.ext);
        chk({tag, "_brk"}, ev_if.ev_break, e.brk);
        chk({tag, "_pause"}, ev_if.ev_pause, e.pause);
      end
      ev_if.ev_ready = 1'b1;
      @(negedge clk);
      ev_if.ev_ready = 1'b0;
    end
    chk({tag, "_left"}, exp_q.size(), 0);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_valid"}, ev_if.ev_valid, 0);
    chk({tag, "_code"}, ev_if.ev_code, 0);
    chk({tag, "_ext"}, ev_if.ev_ext, 0);
    chk({tag, "_brk"}, ev_if.ev_break, 0);
    chk({tag, "_pause"}, ev_if.ev_pause, 0);
    chk({tag, "_err"}, err_cnt, 0);
    chk({tag, "_ovf"}, overflow, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int bad;
    logic [7:0] b;
    logic [7:0] pz [8];
    pz = '{8'hE1, 8'h14, 8'h77, 8'hE1,
           8'hF0, 8'h14, 8'hF0, 8'h77};
    vectors     = 0;
    miscompares = 0;
    exp_err     = 0;
    exp_ovf     = 1'b0;
    ev_if.ev_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk_rst("reset");
    rst_n = 1'b1;

    @(negedge clk);
    frame       = mk(8'h1C, 0);
    frame_valid = 1'b1;
    m_byte(8'h1C);
    @(negedge clk);
    frame_valid = 1'b0;
    chk("lat_e0", ev_if.ev_valid, 0);
    @(negedge clk);
    chk("lat_e1", ev_if.ev_valid, 1);
    chk("lat_code", ev_if.ev_code, 8'h1C);
    drain("make1c");

    send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0);
    drain("e0f075");
    send(8'hF0, 0); send(8'h1C, 0);
    drain("f01c");

    for (int i = 0; i < 8; i++) send(pz[i], 0);
    drain("pause");

    send(8'h1C, 1); send(8'h1C, 2);
    chk("bad_err", err_cnt, exp_err);
    drain("bad");
    send(8'h1C, 0);
    drain("after_bad");

    send(8'hE0, 0);
    repeat (TO + 5) @(negedge clk);
    seq.delete();
    m_err();
    chk("to_err", err_cnt, exp_err);
    send(8'h75, 0);
    drain("after_to");

    @(negedge clk);
    frame = mk(8'hE0, 0); frame_valid = 1'b1; m_byte(8'hE0);
    @(negedge clk);
    frame = mk(8'h75, 0); m_byte(8'h75);
    @(negedge clk);
    frame = mk(8'hF0, 0); m_byte(8'hF0);
    @(negedge clk);
    frame = mk(8'h1C, 0); m_byte(8'h1C);
    @(negedge clk);
    frame_valid = 1'b0;
    drain("b2b");

    for (int i = 0; i <= DEPTH; i++)
      send(8'h15 + 8'(i), 0);
    @(negedge clk);
    chk("ovf_set", overflow, exp_ovf);
    drain("ovf");
    chk("ovf_sticky", overflow, 1);

    send(8'h1C, 0); send(8'h2A, 0);
    @(negedge clk);
    frame = mk(8'h33, 0); frame_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_rst("midrst");
    @(negedge clk);
    frame_valid = 1'b0;
    exp_q.delete(); seq.delete();
    exp_err = 0; exp_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 300; i++) begin
      r   = $urandom_range(0, 99);
      bad = 0;
      b   = 8'($urandom_range(0, 255));
      if (r < 20)      b = 8'hE0;
      else if (r < 35) b = 8'hF0;
      else if (r < 40) b = 8'hE1;
      else if (r < 46) bad = $urandom_range(1, 3);
      send(b, bad);
      drain("rnd");
      chk("rnd_err", err_cnt, exp_err);
    end
    chk("rnd_ovf", overflow, exp_ovf);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
